// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns byte/half/word pipeline ops into word-only memory
// transactions, with read-modify-write for sub-word stores and lane extension for loads.
module lsu_mem_initiator #(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RWAIT, S_WR, S_ERR, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rword_q;
    logic              err_q;

    logic        capture;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign capture    = (state == S_IDLE) && req_valid;
    assign misaligned = (req_size == 2'b11)
                      || ((req_size == 2'b01) && req_addr[0])
                      || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rword_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr[ADDR_W+1:0];
                wdata_q <= req_wdata;
                err_q   <= misaligned;
            end
            if ((state == S_RWAIT) && mem_rvalid) begin
                rword_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned)                          state_nxt = S_ERR;
                    else if (req_we && (req_size == 2'b10))  state_nxt = S_WR;
                    else                                     state_nxt = S_RD;
                end
            end
            S_RD:    if (mem_ready)  state_nxt = S_RWAIT;
            S_RWAIT: if (mem_rvalid) state_nxt = we_q ? S_WR : S_DONE;
            S_WR:    if (mem_ready)  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_lane = rword_q[7:0];
        case (addr_q[1:0])
            2'b00: byte_lane = rword_q[7:0];
            2'b01: byte_lane = rword_q[15:8];
            2'b10: byte_lane = rword_q[23:16];
            2'b11: byte_lane = rword_q[31:24];
            default: byte_lane = rword_q[7:0];
        endcase
        half_lane = addr_q[1] ? rword_q[31:16] : rword_q[15:0];

        load_data = rword_q;
        case (size_q)
            2'b00: load_data = uns_q ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01: load_data = uns_q ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_data = rword_q;
        endcase
    end

    // Sub-word stores overwrite only the addressed lane of the word just read.
    always_comb begin
        merged = rword_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'b00: merged[7:0]   = wdata_q[7:0];
                    2'b01: merged[15:8]  = wdata_q[7:0];
                    2'b10: merged[23:16] = wdata_q[7:0];
                    2'b11: merged[31:24] = wdata_q[7:0];
                    default: merged = rword_q;
                endcase
            end
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    assign mem_req   = (state == S_RD) || (state == S_WR);
    assign mem_we    = (state == S_WR);
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_wdata = (state == S_WR) ? merged : 32'h0000_0000;

    assign busy      = (state == S_IDLE) ? req_valid : (state != S_DONE);
    assign rsp_valid = (state == S_DONE);
    assign rsp_err   = (state == S_DONE) && err_q;
    assign rsp_rdata = ((state == S_DONE) && !we_q && !err_q) ? load_data : 32'h0000_0000;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: a small word memory model answers requests,
// expected responses and write words are queued at issue and popped on completion.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_W(30)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    logic [31:0] model [0:15];
    logic [32:0] exp_rsp_q[$];
    logic [31:0] exp_wr_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One op: issue, then serve the memory side cycle by cycle (sampling on negedge).
    task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_dly, input int rv_dly,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_wword, input int exp_nacc, input int exp_lat);
        int n, nacc, pulses, post, rdy_left, rv_cnt;
        logic acc_pend, stall_pend, done, sv_we;
        logic [29:0] sv_addr;
        logic [31:0] sv_wdata, ew;
        logic [32:0] e;
        n = 0; nacc = 0; pulses = 0; post = 0; rdy_left = rdy_dly; rv_cnt = 0;
        acc_pend = 0; stall_pend = 0; done = 0;
        sv_we = 0; sv_addr = '0; sv_wdata = '0;

        @(negedge clk);
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        exp_rsp_q.push_back({exp_err, exp_rdata});
        if (we && !exp_err) exp_wr_q.push_back(exp_wword);
        #1 check({tag, " busy@capture"}, busy, 1);

        while (n < 60 && post < 2) begin
            @(negedge clk);
            n++;
            if (n == 1) req_valid = 0;
            if (acc_pend) begin
                acc_pend = 0;
                nacc++;
                mem_ready = 0;
                check({tag, " mem_addr"}, sv_addr, addr[31:2]);
                if (sv_we) begin
                    ew = exp_wr_q.pop_front();
                    check({tag, " mem_wdata"}, sv_wdata, ew);
                    model[addr[5:2]] = ew;
                end else begin
                    rv_cnt = rv_dly;
                end
            end
            mem_rvalid = 0;
            mem_rdata = $urandom;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1;
                    mem_rdata = model[addr[5:2]];
                end
            end
            if (rsp_valid) begin
                pulses++;
                if (!done) begin
                    done = 1;
                    e = exp_rsp_q.pop_front();
                    check({tag, " rsp_rdata"}, rsp_rdata, e[31:0]);
                    check({tag, " rsp_err"}, rsp_err, e[32]);
                    if (exp_lat > 0) check({tag, " latency"}, n, exp_lat);
                end
            end else if (done) begin
                post++;
            end
            check({tag, " busy"}, busy, !done);
            if (mem_req) begin
                if (stall_pend) begin
                    check({tag, " stall mem_we"}, mem_we, sv_we);
                    check({tag, " stall mem_addr"}, mem_addr, sv_addr);
                    check({tag, " stall mem_wdata"}, mem_wdata, sv_wdata);
                end
                sv_we = mem_we; sv_addr = mem_addr; sv_wdata = mem_wdata;
                if (rdy_left > 0) begin
                    rdy_left--;
                    mem_ready = 0;
                    stall_pend = 1;
                end else begin
                    mem_ready = 1;
                    acc_pend = 1;
                    stall_pend = 0;
                    rdy_left = rdy_dly;
                end
            end
        end
        mem_rvalid = 0;
        check({tag, " completed"}, done, 1);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " accepts"}, nacc, exp_nacc);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        model[0] = 32'h8180FF7F;
        model[1] = 32'h11223344;
        model[2] = 32'h11223344;
        model[3] = 32'h55667788;

        @(negedge clk); @(negedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset mem_req", mem_req, 0);
        check("reset mem_we", mem_we, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", rsp_err, 0);
        reset = 0;

        //     tag       we  sz    uns addr      wdata         rdy rv exp_rdata      err  wword         acc lat
        do_op("sw",      1, 2'b10, 0, 32'h10, 32'hDEADBEEF,   0, 1, 32'h00000000, 0, 32'hDEADBEEF, 1, 2);
        do_op("lw 10",   0, 2'b10, 0, 32'h10, 32'h0,          0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 3);
        do_op("lb 3",    0, 2'b00, 0, 32'h3,  32'h0,          0, 1, 32'hFFFFFF81, 0, 32'h0,        1, 3);
        do_op("lbu 3",   0, 2'b00, 1, 32'h3,  32'h0,          0, 1, 32'h00000081, 0, 32'h0,        1, 3);
        do_op("lh 2",    0, 2'b01, 0, 32'h2,  32'h0,          0, 1, 32'hFFFF8180, 0, 32'h0,        1, 3);
        do_op("lhu 0",   0, 2'b01, 1, 32'h0,  32'h0,          0, 1, 32'h0000FF7F, 0, 32'h0,        1, 3);
        do_op("lb 0",    0, 2'b00, 0, 32'h0,  32'h0,          0, 1, 32'h0000007F, 0, 32'h0,        1, 3);
        do_op("lw uns",  0, 2'b10, 1, 32'h0,  32'h0,          0, 1, 32'h8180FF7F, 0, 32'h0,        1, 3);
        do_op("sb 5",    1, 2'b00, 0, 32'h5,  32'h123456AA,   0, 1, 32'h00000000, 0, 32'h1122AA44, 2, 4);
        do_op("sh a",    1, 2'b01, 0, 32'hA,  32'h7777BEEF,   0, 1, 32'h00000000, 0, 32'hBEEF3344, 2, 4);
        do_op("lw 6",    0, 2'b10, 0, 32'h6,  32'h0,          0, 1, 32'h00000000, 1, 32'h0,        0, 2);
        do_op("lh 5",    0, 2'b01, 0, 32'h5,  32'h0,          0, 1, 32'h00000000, 1, 32'h0,        0, 2);
        do_op("sz11",    0, 2'b11, 0, 32'h0,  32'h0,          0, 1, 32'h00000000, 1, 32'h0,        0, 2);
        do_op("sw mis",  1, 2'b10, 0, 32'h2,  32'h12345678,   0, 1, 32'h00000000, 1, 32'h0,        0, 2);
        do_op("lw stall",0, 2'b10, 0, 32'h0,  32'h0,          3, 4, 32'h8180FF7F, 0, 32'h0,        1, 9);
        do_op("sb stall",1, 2'b00, 0, 32'h7,  32'h0000005A,   2, 2, 32'h00000000, 0, 32'h5A22AA44, 2, 9);
        do_op("lbu 7",   0, 2'b00, 1, 32'h7,  32'h0,          0, 1, 32'h0000005A, 0, 32'h0,        1, 3);

        // Reset while the read request is still outstanding (ready held low).
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'hC;
        @(negedge clk);
        req_valid = 0;
        check("rst RD mem_req before", mem_req, 1);
        reset = 1;
        #1 check("rst RD mem_req", mem_req, 0);
        @(negedge clk);
        reset = 0;

        // Reset in RWAIT, then a stale read return must be ignored.
        @(negedge clk);
        req_valid = 1;
        @(negedge clk);
        req_valid = 0; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        check("rst RWAIT busy before", busy, 1);
        reset = 1;
        #1;
        check("rst RWAIT mem_req", mem_req, 0);
        check("rst RWAIT busy", busy, 0);
        @(negedge clk);
        reset = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 0;
            check("rst no rsp_valid", rsp_valid, 0);
            check("rst idle mem_req", mem_req, 0);
            check("rst idle busy", busy, 0);
        end

        do_op("lw after rst", 0, 2'b10, 0, 32'hC, 32'h0, 0, 1, 32'h55667788, 0, 32'h0, 1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
